// File: rtl/itch_order_serializer.sv
// itch_order_serializer: snapshots the buy/sell Add Order register sets from the
// reverse parser and streams them as two back-to-back messages, buy then sell,
// one byte per handshake on an AXI-Stream style interface.
// Optional build macro ITCH_LEN_PREFIX_EN prepends a 2-byte big-endian length
// (0x00, 0x24) to each message.
module itch_order_serializer #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 9
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REGS*REG_WIDTH-1:0] i_buy_regs,
  input  logic [NUM_REGS*REG_WIDTH-1:0] i_sell_regs,
  input  logic                          i_valid,
  output logic [7:0]                    o_tdata,
  output logic                          o_tvalid,
  input  logic                          i_tready,
  output logic                          o_tlast,
  output logic                          o_tuser,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_drop,
  output logic [15:0]                   o_msg_count
);

  localparam int BUF_W   = NUM_REGS * REG_WIDTH;
  localparam int PAY_LEN = BUF_W / 8;
`ifdef ITCH_LEN_PREFIX_EN
  localparam int PFX_LEN = 2;
`else
  localparam int PFX_LEN = 0;
`endif
  localparam int MSG_LEN = PAY_LEN + PFX_LEN;
  localparam logic [5:0]  LAST_IDX = 6'(MSG_LEN - 1);
  localparam logic [15:0] LEN_FIELD = 16'(PAY_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUY  = 2'd1;
  localparam logic [1:0] S_SELL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic             armed_q, armed_d;
  logic [BUF_W-1:0] buy_buf_q, buy_buf_d;
  logic [BUF_W-1:0] sell_buf_q, sell_buf_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             sending;
  logic             at_last;
  logic             capture;
  logic             refuse;
  logic [PAY_LEN-1:0][7:0] src_bytes;
  logic [5:0]       pay_idx;
  logic [7:0]       cur_byte;

  assign sending = (state_q != S_IDLE);
  assign at_last = (idx_q == LAST_IDX);
  // A fresh rising level of i_valid is only honoured once; busy means refuse.
  assign capture = !sending && i_valid && armed_q;
  assign refuse  = sending && i_valid && armed_q;

  // Byte mux: the payload buffer for the active side, behind the optional prefix.
  always_comb begin
    src_bytes = (state_q == S_SELL) ? sell_buf_q : buy_buf_q;
    pay_idx   = idx_q - 6'(PFX_LEN);
    cur_byte  = src_bytes[pay_idx];
`ifdef ITCH_LEN_PREFIX_EN
    if (idx_q == 6'd0)      cur_byte = LEN_FIELD[15:8];
    else if (idx_q == 6'd1) cur_byte = LEN_FIELD[7:0];
`endif
  end

  // Next-state logic: capture/drop arbitration, byte index and message sequencing.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    armed_d    = armed_q;
    buy_buf_d  = buy_buf_q;
    sell_buf_d = sell_buf_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    drop_d     = refuse;

    if (!i_valid)              armed_d = 1'b1;
    else if (capture || refuse) armed_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          buy_buf_d  = i_buy_regs;
          sell_buf_d = i_sell_regs;
          idx_d      = '0;
          state_d    = S_BUY;
        end
      end
      S_BUY, S_SELL: begin
        if (i_tready) begin
          if (at_last) begin
            idx_d   = '0;
            cnt_d   = cnt_q + 16'd1;
            state_d = (state_q == S_BUY) ? S_SELL : S_IDLE;
            done_d  = (state_q == S_SELL);
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any partial message immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      armed_q    <= 1'b1;
      buy_buf_q  <= '0;
      sell_buf_q <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      armed_q    <= armed_d;
      buy_buf_q  <= buy_buf_d;
      sell_buf_q <= sell_buf_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_tvalid    = sending;
  assign o_busy      = sending;
  assign o_tuser     = (state_q == S_SELL);
  assign o_tlast     = sending && at_last;
  assign o_tdata     = sending ? cur_byte : 8'h00;
  assign o_done      = done_q;
  assign o_drop      = drop_q;
  assign o_msg_count = cnt_q;

endmodule
